// File: rtl/monopulse_pkg.sv
// Shared defaults and FSM state encoding for the monopulse sample sequencer.
package monopulse_pkg;

    localparam int MONO_DATA_SIZE   = 64;
    localparam int MONO_ADDR_WIDTH  = 10;
    localparam int MONO_MEM_LATENCY = 2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_WAIT_MEM = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_DIV = 3'd4,
        S_DONE     = 3'd5
    } mono_state_t;

endpackage

// File: rtl/monopulse_sequencer.sv
// Walks N sample pairs out of memory, feeds each to the monopulse divider and reports results.
// Optional MONOPULSE_ZERO_GUARD_EN: zero references bypass the divider and yield relation 0.
module monopulse_sequencer
    import monopulse_pkg::*;
#(
    parameter int DATA_SIZE   = MONO_DATA_SIZE,
    parameter int ADDR_WIDTH  = MONO_ADDR_WIDTH,
    parameter int MEM_LATENCY = MONO_MEM_LATENCY
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_count,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_SIZE-1:0]  i_mem_reference,
    input  logic [DATA_SIZE-1:0]  i_mem_error,
    output logic                  o_mono_start,
    output logic [DATA_SIZE-1:0]  o_mono_reference,
    output logic [DATA_SIZE-1:0]  o_mono_error,
    input  logic                  i_mono_done,
    input  logic [DATA_SIZE-1:0]  i_mono_relation,
    output logic [DATA_SIZE-1:0]  o_relation,
    output logic                  o_relation_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_zero_ref,
    output logic [2:0]            o_dbg_state
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0]      LAT_ONE  = LAT_W'(1);
    localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(MEM_LATENCY);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);

    mono_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [LAT_W-1:0]      r_lat;
    logic                  r_mem_en;
    logic                  r_mono_start;
    logic                  r_relation_valid;
    logic                  r_done;
    logic [DATA_SIZE-1:0]  r_mono_reference;
    logic [DATA_SIZE-1:0]  r_mono_error;
    logic [DATA_SIZE-1:0]  r_relation;
`ifdef MONOPULSE_ZERO_GUARD_EN
    logic                  r_zero_ref;
`endif

    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_index_next;

    assign w_last       = (r_index == (r_count - IDX_ONE));
    assign w_index_next = r_index + IDX_ONE;

    // All strobes (mem_en, mono_start, relation_valid, done) are single-cycle pulses with
    // no back-pressure; i_mono_done is only listened to while a divide is outstanding.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state          <= S_IDLE;
            r_index          <= '0;
            r_count          <= '0;
            r_mem_addr       <= '0;
            r_lat            <= '0;
            r_mem_en         <= 1'b0;
            r_mono_start     <= 1'b0;
            r_relation_valid <= 1'b0;
            r_done           <= 1'b0;
            r_mono_reference <= '0;
            r_mono_error     <= '0;
            r_relation       <= '0;
`ifdef MONOPULSE_ZERO_GUARD_EN
            r_zero_ref       <= 1'b0;
`endif
        end else begin
            r_mem_en         <= 1'b0;
            r_mono_start     <= 1'b0;
            r_relation_valid <= 1'b0;
            r_done           <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= i_count;
                        r_index <= '0;
`ifdef MONOPULSE_ZERO_GUARD_EN
                        r_zero_ref <= 1'b0;
`endif
                        if (i_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_READ;
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= '0;
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT_MEM;
                    r_lat   <= LAT_ONE;
                end
                S_WAIT_MEM: begin
                    // r_lat counts edges since the strobe edge; capture on edge MEM_LATENCY.
                    if (r_lat == LAT_LAST) begin
                        r_lat            <= '0;
                        r_mono_reference <= i_mem_reference;
                        r_mono_error     <= i_mem_error;
`ifdef MONOPULSE_ZERO_GUARD_EN
                        if (i_mem_reference == '0) begin
                            r_relation       <= '0;
                            r_relation_valid <= 1'b1;
                            r_zero_ref       <= 1'b1;
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_index    <= w_index_next;
                                r_mem_addr <= w_index_next;
                                r_mem_en   <= 1'b1;
                                r_state    <= S_READ;
                            end
                        end else
`endif
                        begin
                            r_state      <= S_ISSUE;
                            r_mono_start <= 1'b1;
                        end
                    end else begin
                        r_lat <= r_lat + LAT_ONE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_DIV;
                end
                S_WAIT_DIV: begin
                    if (i_mono_done) begin
                        r_relation       <= i_mono_relation;
                        r_relation_valid <= 1'b1;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index    <= w_index_next;
                            r_mem_addr <= w_index_next;
                            r_mem_en   <= 1'b1;
                            r_state    <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_en         = r_mem_en;
    assign o_mem_addr       = r_mem_addr;
    assign o_mono_start     = r_mono_start;
    assign o_mono_reference = r_mono_reference;
    assign o_mono_error     = r_mono_error;
    assign o_relation       = r_relation;
    assign o_relation_valid = r_relation_valid;
    assign o_busy           = (r_state != S_IDLE);
    assign o_done           = r_done;
    assign o_dbg_state      = r_state;
`ifdef MONOPULSE_ZERO_GUARD_EN
    assign o_zero_ref       = r_zero_ref;
`else
    assign o_zero_ref       = 1'b0;
`endif

endmodule

// File: tb/tb_monopulse_sequencer.sv
// Bench for monopulse_sequencer: memory and divider models, vector table, random runs, corner sequences.
module tb_monopulse_sequencer;
  import monopulse_pkg::*;

  localparam int DW  = 64;
  localparam int AW  = 10;
  localparam int LAT = 2;
`ifdef MONOPULSE_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [DW-1:0] HALF    = 64'h0000_0000_8000_0000;
  localparam logic [DW-1:0] QUARTER = 64'h0000_0000_4000_0000;
  localparam logic [DW-1:0] ONE     = 64'h0000_0001_0000_0000;
  localparam logic [DW-1:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_start = 1'b0;
  logic [AW-1:0] i_count = '0;
  logic          o_mem_en;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] i_mem_reference, i_mem_error;
  logic          o_mono_start;
  logic [DW-1:0] o_mono_reference, o_mono_error;
  logic          i_mono_done;
  logic [DW-1:0] i_mono_relation;
  logic [DW-1:0] o_relation;
  logic          o_relation_valid, o_busy, o_done, o_zero_ref;
  logic [2:0]    o_dbg_state;

  monopulse_sequencer #(.DATA_SIZE(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(i_start), .i_count(i_count),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
    .i_mem_reference(i_mem_reference), .i_mem_error(i_mem_error),
    .o_mono_start(o_mono_start), .o_mono_reference(o_mono_reference), .o_mono_error(o_mono_error),
    .i_mono_done(i_mono_done), .i_mono_relation(i_mono_relation),
    .o_relation(o_relation), .o_relation_valid(o_relation_valid),
    .o_busy(o_busy), .o_done(o_done), .o_zero_ref(o_zero_ref), .o_dbg_state(o_dbg_state)
  );

  // sample memory with a LAT-stage read pipeline; non-strobed cycles push poison
  logic [DW-1:0] mem_ref [0:1023];
  logic [DW-1:0] mem_err [0:1023];
  logic [DW-1:0] pipe_ref [LAT];
  logic [DW-1:0] pipe_err [LAT];
  always @(posedge clk) begin
    pipe_ref[0] <= o_mem_en ? mem_ref[o_mem_addr] : 64'hDEAD_BEEF_DEAD_BEEF;
    pipe_err[0] <= o_mem_en ? mem_err[o_mem_addr] : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int k = 1; k < LAT; k++) begin
      pipe_ref[k] <= pipe_ref[k-1];
      pipe_err[k] <= pipe_err[k-1];
    end
  end
  assign i_mem_reference = pipe_ref[LAT-1];
  assign i_mem_error     = pipe_err[LAT-1];

  // divider: Q32.32 err/ref, all-ones on divide by zero
  function automatic logic [DW-1:0] div_model(input logic [DW-1:0] r, input logic [DW-1:0] e);
    if (r == '0) return ALL1;
    return (e << 32) / r;
  endfunction

  int            div_cnt = 0;
  logic [DW-1:0] div_res = '0;
  logic          div_done = 1'b0;
  logic          inj_done = 1'b0;
  logic [DW-1:0] inj_rel = '0;
  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_cnt > 0) begin
      div_cnt <= div_cnt - 1;
      if (div_cnt == 1) div_done <= 1'b1;
    end
    if (o_mono_start) begin
      div_cnt <= 3;
      div_res <= div_model(o_mono_reference, o_mono_error);
    end
  end
  assign i_mono_done     = div_done | inj_done;
  assign i_mono_relation = inj_done ? inj_rel : div_res;

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int exp_mono;
  bit exp_zero;
  logic [DW-1:0] last_rel = '0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // spec-level model of one run over the current memory contents
  function automatic logic [DW-1:0] rel_model(input logic [DW-1:0] r, input logic [DW-1:0] e);
    if (GUARD && r == '0) return '0;
    return div_model(r, e);
  endfunction

  task automatic build_expect(input int n);
    exp_q = {};
    exp_mono = 0;
    exp_zero = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(rel_model(mem_ref[i], mem_err[i]));
      if (GUARD && mem_ref[i] == '0) exp_zero = 1'b1;
      else exp_mono++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, 64'(o_mem_en), 64'd0);
    chk({tag, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
    chk({tag, "_mono_start"}, 64'(o_mono_start), 64'd0);
    chk({tag, "_mono_ref"}, o_mono_reference, 64'd0);
    chk({tag, "_mono_err"}, o_mono_error, 64'd0);
    chk({tag, "_relation"}, o_relation, 64'd0);
    chk({tag, "_rel_valid"}, 64'(o_relation_valid), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_done"}, 64'(o_done), 64'd0);
    chk({tag, "_zero_ref"}, 64'(o_zero_ref), 64'd0);
  endtask

  // driver + monitor for one run; compares against exp_q / exp_mono / exp_zero
  task automatic run_case(input int n, input bit spur);
    logic [DW-1:0] obs_rel[$];
    int obs_addr[$];
    int mono_cnt = 0, done_cnt = 0, busy_low = 0, done_cyc = -1, spur_cyc = -1, extra = -1;
    bit coincide = 1'b1;
    int bound = n * 20 + 40;
    @(negedge clk);
    i_start = 1'b1;
    i_count = AW'(n);
    @(negedge clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < bound; cyc++) begin
      if (o_mem_en) obs_addr.push_back(int'(o_mem_addr));
      if (o_mono_start) begin
        mono_cnt++;
        if (mono_cnt == 2) spur_cyc = cyc + 1;
      end
      if (o_relation_valid) obs_rel.push_back(o_relation);
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (n > 0 && !o_relation_valid) coincide = 1'b0;
      end
      if (done_cyc < 0 && !o_busy) busy_low++;
      if (done_cyc >= 0 && extra < 0) extra = 6;
      if (extra == 0) break;
      if (extra > 0) extra--;
      i_start = spur && (cyc == spur_cyc);
      if (i_start) i_count = AW'(7);
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'd1);
    chk("done_count", 64'(done_cnt), 64'd1);
    if (n == 0) chk("done_latency", 64'(done_cyc), 64'd0);
    chk("strobe_count", 64'(obs_addr.size()), 64'(n));
    for (int i = 0; i < obs_addr.size() && i < n; i++) chk("strobe_addr", 64'(obs_addr[i]), 64'(i));
    chk("result_count", 64'(obs_rel.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_rel.size() && i < exp_q.size(); i++) chk("relation", obs_rel[i], exp_q[i]);
    chk("mono_starts", 64'(mono_cnt), 64'(exp_mono));
    if (n > 0) chk("done_with_valid", 64'(coincide), 64'd1);
    chk("busy_gaps", 64'(busy_low), 64'd0);
    chk("busy_idle", 64'(o_busy), 64'd0);
    chk("zero_ref", 64'(o_zero_ref), 64'(exp_zero));
    if (exp_q.size() > 0) begin
      last_rel = exp_q[exp_q.size()-1];
      chk("relation_hold", o_relation, last_rel);
    end
  endtask

  typedef struct {
    int            n;
    logic [DW-1:0] r [4];
    logic [DW-1:0] e [4];
    logic [DW-1:0] x [4];
    int            mono;
    bit            zref;
  } vec_t;

  function automatic vec_t mk(input int n,
      input logic [DW-1:0] r0, r1, r2, r3, input logic [DW-1:0] e0, e1, e2, e3,
      input logic [DW-1:0] x0, x1, x2, x3, input int mono, input bit zref);
    vec_t v;
    v.n = n;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
    v.mono = mono;
    v.zref = zref;
    return v;
  endfunction

  vec_t vt [5];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_ref[i] = 64'($urandom_range(1, 1000));
      mem_err[i] = 64'($urandom_range(0, 1000));
    end
    vt[0] = mk(3, 10, 20, 30, 1, 5, 5, 15, 0, HALF, QUARTER, HALF, 0, 3, 1'b0);
    vt[1] = mk(1, 4, 9, 9, 9, 1, 9, 9, 9, QUARTER, 0, 0, 0, 1, 1'b0);
    vt[2] = mk(2, 8, 2, 9, 9, 6, 1, 9, 9, HALF + QUARTER, HALF, 0, 0, 2, 1'b0);
    vt[3] = mk(3, 7, 0, 5, 9, 7, 3, 5, 9, ONE, GUARD ? 64'd0 : ALL1, ONE, 0,
               GUARD ? 2 : 3, GUARD);
    vt[4] = mk(0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1'b0);

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // table vectors
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) begin
        mem_ref[i] = vt[v].r[i];
        mem_err[i] = vt[v].e[i];
      end
      exp_q = {};
      for (int i = 0; i < vt[v].n; i++) exp_q.push_back(vt[v].x[i]);
      exp_mono = vt[v].mono;
      exp_zero = vt[v].zref;
      run_case(vt[v].n, 1'b0);
    end

    // i_mono_done in IDLE is ignored and o_relation keeps the last run's value
    begin
      int vcnt = 0;
      @(negedge clk);
      inj_rel = 64'h1234_5678_9ABC_DEF0;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (o_relation_valid) vcnt++;
        @(negedge clk);
      end
      chk("idle_done_valid", 64'(vcnt), 64'd0);
      chk("idle_done_relation", o_relation, last_rel);
    end

    // random runs against the model
    for (int t = 0; t < 6; t++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        mem_ref[i] = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 1000));
        mem_err[i] = 64'($urandom_range(0, 1000));
      end
      build_expect(n);
      run_case(n, 1'b0);
    end

    // start pulsed during WAIT_DIV of sample 1 is dropped
    for (int i = 0; i < 4; i++) begin
      mem_ref[i] = 64'($urandom_range(1, 1000));
      mem_err[i] = 64'($urandom_range(0, 1000));
    end
    build_expect(4);
    run_case(4, 1'b1);

    // reset during WAIT_DIV of sample 1 aborts the run
    begin
      int starts = 0, late = 0;
      bit reached = 1'b0;
      @(negedge clk);
      i_start = 1'b1;
      i_count = AW'(4);
      @(negedge clk);
      i_start = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (o_mono_start) starts++;
        @(negedge clk);
        if (starts == 2) begin
          reached = 1'b1;
          break;
        end
      end
      chk("abort_reached", 64'(reached), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (o_relation_valid || o_done || o_busy) late++;
      end
      chk("abort_late_done", 64'(late), 64'd0);
      build_expect(3);
      run_case(3, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
